i2c_bus_arbiter: RTL and testbench

//  Shares one open-drain I2C bus (SCL/SDA pads) between REQUESTER_COUNT I2C

---
 rtl/i2c_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_arbiter
// Purpose  : Round-robin owner selection for one shared open-drain I2C bus.
//            Only the granted master's SCL/SDA drives reach the pads; an idle
//            gap separates owners and an optional watchdog revokes a grant
//            that is held too long.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_arbiter #(
  parameter int unsigned REQUESTER_COUNT = 4,
  parameter int unsigned GAP_CYCLES      = 64,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [REQUESTER_COUNT-1:0]         request,
  output logic [REQUESTER_COUNT-1:0]         grant,
  input  logic [REQUESTER_COUNT-1:0]         scl_output_vector,
  input  logic [REQUESTER_COUNT-1:0]         sda_output_vector,
  output logic                               scl_output,
  output logic                               sda_output,
  output logic [$clog2(REQUESTER_COUNT)-1:0] owner,
  output logic                               busy,
  output logic                               timeout
);

  localparam int unsigned c_owner_w = $clog2(REQUESTER_COUNT);

  // Last gap count value; a zero gap still spends one cycle in the gap state.
  localparam logic [15:0] c_gap_last =
    (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

  // Watchdog fires on the edge that would complete TIMEOUT_CYCLES of ownership.
  localparam logic [31:0] c_wd_last = TIMEOUT_CYCLES - 32'd1;
  localparam logic        c_wd_on   = (TIMEOUT_CYCLES != 32'd0);

  // Owner resets to the top index so that master 0 is searched first.
  localparam logic [c_owner_w-1:0]       c_owner_rst = c_owner_w'(REQUESTER_COUNT - 1);
  localparam logic [REQUESTER_COUNT-1:0] c_one_hot0  = REQUESTER_COUNT'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_GAP     = 2'd2
  } state_t;

  state_t                       r_state;
  logic [REQUESTER_COUNT-1:0]   r_grant;
  logic [REQUESTER_COUNT-1:0]   r_mask;
  logic [c_owner_w-1:0]         r_owner;
  logic                         r_timeout;
  logic [15:0]                  r_gap_cnt;
  logic [31:0]                  r_wd_cnt;

  logic [REQUESTER_COUNT-1:0]   w_eligible;
  logic                         w_found;
  logic [c_owner_w-1:0]         w_winner;
  logic                         w_owner_req;
  logic                         w_wd_expire;

  assign w_eligible  = request & ~r_mask;
  assign w_owner_req = request[r_owner];
  assign w_wd_expire = c_wd_on && (r_wd_cnt == c_wd_last);

  // Round-robin search: first eligible master after the current owner, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_owner;
    for (int k = 1; k <= int'(REQUESTER_COUNT); k++) begin
      if (!w_found &&
          w_eligible[(int'(r_owner) + k) % int'(REQUESTER_COUNT)]) begin
        w_found  = 1'b1;
        w_winner = c_owner_w'((int'(r_owner) + k) % int'(REQUESTER_COUNT));
      end
    end
  end

  // Arbitration FSM with registered grant, owner, timeout pulse and mask.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_mask    <= '0;
      r_owner   <= c_owner_rst;
      r_timeout <= 1'b0;
      r_gap_cnt <= '0;
      r_wd_cnt  <= '0;
    end else begin
      r_timeout <= 1'b0;
      // A master that lets go of request is forgiven for an earlier timeout.
      r_mask    <= r_mask & request;

      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant  <= c_one_hot0 << w_winner;
            r_owner  <= w_winner;
            r_wd_cnt <= '0;
            r_state  <= ST_GRANTED;
          end
        end

        ST_GRANTED: begin
          if (!w_owner_req) begin
            // Normal release wins over a watchdog expiring on the same edge.
            r_grant   <= '0;
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end else if (w_wd_expire) begin
            r_grant   <= '0;
            r_timeout <= 1'b1;
            r_mask    <= (r_mask & request) | r_grant;
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end else if (c_wd_on) begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
          end
        end

        ST_GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end

        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pad mux: only the owner's drives pass while granted; otherwise release.
  always_comb begin
    scl_output = 1'b1;
    sda_output = 1'b1;
    if (r_state == ST_GRANTED) begin
      scl_output = scl_output_vector[r_owner];
      sda_output = sda_output_vector[r_owner];
    end
  end

  assign grant   = r_grant;
  assign owner   = r_owner;
  assign timeout = r_timeout;
  assign busy    = |r_grant;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_arbiter
// Purpose  : Directed self-checking bench for i2c_bus_arbiter (4 masters,
//            gap of 8 cycles, watchdog of 100 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned GAP = 8;
  localparam logic [31:0] TO  = 32'd100;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] request;
  logic [N-1:0] grant;
  logic [N-1:0] scl_v;
  logic [N-1:0] sda_v;
  logic         scl_output;
  logic         sda_output;
  logic [1:0]   owner;
  logic         busy;
  logic         timeout;

  int n_checks = 0;
  int n_err    = 0;

  i2c_bus_arbiter #(
    .REQUESTER_COUNT(N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .request          (request),
    .grant            (grant),
    .scl_output_vector(scl_v),
    .sda_output_vector(sda_v),
    .scl_output       (scl_output),
    .sda_output       (sda_output),
    .owner            (owner),
    .busy             (busy),
    .timeout          (timeout)
  );

  // Free-running clock, 10 ns period.
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance until a grant appears (bounded); zeros = grant-low samples seen.
  task automatic wait_grant(output int zeros);
    zeros = 0;
    for (int i = 0; i < 200 && grant == '0; i++) begin
      tick();
      if (grant == '0) zeros++;
    end
  endtask

  int   z;
  logic hold_ok;
  int   order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset   = 1'b1;
    request = '0;
    scl_v   = '0;
    sda_v   = '0;
    tick();
    tick();
    check("rst_grant",   32'(grant),   32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_owner",   32'(owner),   32'd3);
    reset = 1'b0;
    tick();
    check("idle_scl", 32'(scl_output), 32'h1);
    check("idle_sda", 32'(sda_output), 32'h1);

    // Single requester: one-cycle grant latency, release, gap before re-grant.
    scl_v   = '1;
    sda_v   = '1;
    request = 4'b0001;
    tick();
    check("single_grant", 32'(grant), 32'h1);
    check("single_busy",  32'(busy),  32'h1);
    check("single_owner", 32'(owner), 32'd0);
    repeat (3) tick();
    request = 4'b0000;
    tick();
    check("single_release", 32'(grant), 32'h0);
    check("single_nbusy",   32'(busy),  32'h0);
    check("single_owner_hold", 32'(owner), 32'd0);
    scl_v = '0;
    sda_v = '0;
    #1;
    check("gap_scl", 32'(scl_output), 32'h1);
    check("gap_sda", 32'(sda_output), 32'h1);
    request = 4'b0001;
    wait_grant(z);
    check("single_gap_len", 32'(z),     32'(GAP));
    check("single_regrant", 32'(grant), 32'h1);
    check("own_scl_low", 32'(scl_output), 32'h0);
    check("own_sda_low", 32'(sda_output), 32'h0);

    // Asynchronous reset while granted: outputs release without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("arst_grant", 32'(grant),      32'h0);
    check("arst_busy",  32'(busy),       32'h0);
    check("arst_scl",   32'(scl_output), 32'h1);
    check("arst_sda",   32'(sda_output), 32'h1);
    check("arst_owner", 32'(owner),      32'd3);
    request = '0;
    scl_v   = '1;
    sda_v   = '1;
    tick();
    tick();
    reset = 1'b0;

    // Round robin with all four masters requesting; each holds 10 cycles.
    request = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_grant(z);
      if (j == 0) check("rr_first_latency", 32'(z), 32'h0);
      else        check("rr_gap_len",       32'(z), 32'(GAP));
      check("rr_grant", 32'(grant), 32'(4'b0001 << order[j]));
      check("rr_owner", 32'(owner), 32'(order[j]));
      if (order[j] == 2) begin
        scl_v = 4'b1011;
        #1;
        check("mux_scl_owner2", 32'(scl_output), 32'h0);
        check("mux_sda_owner2", 32'(sda_output), 32'h1);
        scl_v = 4'b1111;
      end
      repeat (9) tick();
      request[order[j]] = 1'b0;
      tick();
      check("rr_release", 32'(grant), 32'h0);
      request[order[j]] = 1'b1;
    end
    request = '0;
    repeat (GAP + 2) tick();

    // Watchdog: master 1 holds too long; master 3 waits behind it.
    request = 4'b1010;
    tick();
    check("wd_grant", 32'(grant), 32'h2);
    hold_ok = 1'b1;
    repeat (99) begin
      tick();
      if (grant !== 4'b0010 || timeout !== 1'b0) hold_ok = 1'b0;
    end
    check("wd_hold_100", 32'(hold_ok), 32'h1);
    tick();
    check("wd_revoke", 32'(grant),   32'h0);
    check("wd_pulse",  32'(timeout), 32'h1);
    tick();
    check("wd_pulse_end", 32'(timeout), 32'h0);
    // One gap sample was already consumed by the pulse-end check.
    wait_grant(z);
    check("wd_gap_len",  32'(z),     32'(GAP - 1));
    check("wd_next_m3",  32'(grant), 32'h8);
    request = 4'b0010;
    tick();
    hold_ok = 1'b1;
    repeat (GAP + 5) begin
      tick();
      if (grant !== 4'b0000) hold_ok = 1'b0;
    end
    check("mask_blocks", 32'(hold_ok), 32'h1);
    request = 4'b0000;
    tick();
    request = 4'b0010;
    wait_grant(z);
    check("mask_regrant", 32'(grant), 32'h2);

    // Request drop on the watchdog's expiry edge counts as a normal release.
    repeat (99) tick();
    request = 4'b0000;
    tick();
    check("sim_release",  32'(grant),   32'h0);
    check("sim_no_pulse", 32'(timeout), 32'h0);
    tick();
    check("sim_no_pulse2", 32'(timeout), 32'h0);
    request = 4'b0010;
    wait_grant(z);
    check("sim_no_mask", 32'(grant), 32'h2);
    request = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
